// File: rtl/handshake_tx_fifo_if.sv
// ----------------------------------------------------------------------------
// handshake_tx_fifo_if
//   Producer-side write channel and CDC-side read channel of handshake_tx_fifo.
//   Signals:
//     in_data/in_valid/in_ready     producer -> FIFO write handshake
//     out_data/out_valid/out_ready  FIFO -> CDC source port handshake
//   Modports:
//     slave   the FIFO itself
//     master  the environment (producer + CDC source port)
// ----------------------------------------------------------------------------
interface handshake_tx_fifo_if #(
   parameter int DATA_WIDTH = 4
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid
   );
endinterface

// File: rtl/handshake_tx_fifo.sv
// ----------------------------------------------------------------------------
// handshake_tx_fifo
//   First-word-fall-through elastic buffer feeding the handshake CDC source port.
//   Absorbs producer bursts and presents one word at a time downstream.
//   Ports:
//     clk          source-domain clock
//     rst_n        synchronous reset, active low
//     flush        synchronous clear of contents (reset has priority)
//     bus          handshake_tx_fifo_if.slave: write channel (in_*) and
//                  read channel (out_*) handshakes
//     level        number of stored words, 0..DEPTH
//     almost_full  level >= AFULL_LEVEL
// ----------------------------------------------------------------------------
module handshake_tx_fifo #(
   parameter int DATA_WIDTH  = 4,
   parameter int DEPTH       = 8,
   parameter int AFULL_LEVEL = 6
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   handshake_tx_fifo_if.slave       bus,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     almost_full
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
   localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_LEVEL);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [LW-1:0]         r_level;

   logic                  w_in_ready;
   logic                  w_out_valid;
   logic                  w_push;
   logic                  w_pop;

   // Status flags come only from registered level, so in_ready never
   // depends on out_ready (a pop while full does not open a push slot).
   assign w_in_ready  = (r_level != FULL_LVL);
   assign w_out_valid = (r_level != '0);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   // Head word falls through from storage; forced to zero when empty so
   // stale contents never show on the CDC data lines.
   assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
   assign level         = r_level;
   assign almost_full   = (r_level >= AFULL_LVL);

   // Storage is not reset; writes discarded under reset/flush keep the
   // array consistent with the pointer state either way.
   always_ff @(posedge clk) begin
      if (rst_n && !flush && w_push) begin
         r_mem[r_wr_ptr] <= bus.in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: tb/tb_handshake_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_handshake_tx_fifo
//   Directed self-checking bench for handshake_tx_fifo (DATA_WIDTH=4,
//   DEPTH=8, AFULL_LEVEL=6). Inputs change and outputs are sampled 1 time
//   unit after the rising edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_handshake_tx_fifo;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic [3:0] level;
   logic       almost_full;

   int unsigned n_checks;
   int unsigned n_fail;

   handshake_tx_fifo_if #(.DATA_WIDTH(4)) bus ();

   handshake_tx_fifo #(
      .DATA_WIDTH  (4),
      .DEPTH       (8),
      .AFULL_LEVEL (6)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .bus         (bus.slave),
      .level       (level),
      .almost_full (almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned accepts;
      int unsigned countdown;
      int unsigned acc_cyc [3];
      logic [3:0]  exp_abc [3];

      n_checks = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      bus.in_data   = 4'h5;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;

      // 1. Reset held 3 clocks with in_valid high
      repeat (3) tick();
      check("rst_level",  32'(level), 0);
      check("rst_ovalid", 32'(bus.out_valid), 0);
      check("rst_iready", 32'(bus.in_ready), 1);
      check("rst_odata",  32'(bus.out_data), 0);
      check("rst_afull",  32'(almost_full), 0);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      tick();

      // 2. Fill 1..8 with out_ready low
      for (int i = 1; i <= 8; i++) begin
         bus.in_data  = 4'(i);
         bus.in_valid = 1'b1;
         tick();
         check("fill_level", 32'(level), 32'(i));
         check("fill_afull", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
      end
      check("full_iready", 32'(bus.in_ready), 0);
      check("full_head",   32'(bus.out_data), 1);
      bus.in_data = 4'h9;
      tick();
      check("ninth_level", 32'(level), 8);
      bus.in_valid = 1'b0;

      // 3. Drain in order
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check("drain_valid", 32'(bus.out_valid), 1);
         check("drain_data",  32'(bus.out_data), 32'(i));
         tick();
      end
      check("drained_valid", 32'(bus.out_valid), 0);
      check("drained_level", 32'(level), 0);
      check("drained_data",  32'(bus.out_data), 0);
      bus.out_ready = 1'b0;

      // 4. Concurrent push/pop at level 3, 20 pairs (pointers wrap twice)
      for (int i = 1; i <= 3; i++) begin
         bus.in_data  = 4'(i);
         bus.in_valid = 1'b1;
         tick();
      end
      check("pp_start_level", 32'(level), 3);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.in_data = 4'(k + 4);
         check("pp_data", 32'(bus.out_data), 32'((k + 1) % 16));
         tick();
         check("pp_level", 32'(level), 3);
      end
      bus.in_valid = 1'b0;
      for (int k = 21; k <= 23; k++) begin
         check("pp_tail", 32'(bus.out_data), 32'(k % 16));
         tick();
      end
      check("pp_end_level", 32'(level), 0);
      bus.out_ready = 1'b0;

      // 5. CDC-style ready: high until accept, then low for 5 cycles
      exp_abc[0] = 4'hA;
      exp_abc[1] = 4'hB;
      exp_abc[2] = 4'hC;
      accepts   = 0;
      countdown = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         bus.in_valid  = (cyc < 3);
         bus.in_data   = 4'(4'hA + cyc);
         bus.out_ready = (countdown == 0);
         if (bus.out_valid && accepts < 3) begin
            check("cdc_data", 32'(bus.out_data), 32'(exp_abc[accepts]));
            if (bus.out_ready) begin
               acc_cyc[accepts] = cyc;
               accepts++;
               countdown = 5;
            end else begin
               countdown--;
            end
         end else if (countdown != 0) begin
            countdown--;
         end
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("cdc_accepts", accepts, 3);
      if (accepts == 3) begin
         check("cdc_acc0", acc_cyc[0], 1);
         check("cdc_acc1", acc_cyc[1], 7);
         check("cdc_acc2", acc_cyc[2], 13);
      end
      check("cdc_empty", 32'(level), 0);

      // 6. Flush at level 5 with concurrent push and pop
      for (int i = 1; i <= 5; i++) begin
         bus.in_data  = 4'(i);
         bus.in_valid = 1'b1;
         tick();
      end
      check("fl_pre_level", 32'(level), 5);
      flush         = 1'b1;
      bus.in_data   = 4'hE;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check("fl_level",  32'(level), 0);
      check("fl_ovalid", 32'(bus.out_valid), 0);
      check("fl_iready", 32'(bus.in_ready), 1);
      check("fl_odata",  32'(bus.out_data), 0);
      bus.in_data  = 4'h7;
      bus.in_valid = 1'b1;
      check("fl_nobypass", 32'(bus.out_valid), 0);
      tick();
      bus.in_valid = 1'b0;
      check("fl_push_data",  32'(bus.out_data), 7);
      check("fl_push_valid", 32'(bus.out_valid), 1);
      check("fl_push_level", 32'(level), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
